// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch-to-decode pipeline register.
package fetch_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 32;
  localparam int DEF_LANES  = 2;
  localparam int SQUASH_W   = 16;

  // Instruction word driven on lanes that carry no valid instruction.
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_INSTR = 32'h0;

  // One fetch bundle at the default geometry: lane mask, instructions, PCs.
  // Lane i of each packed array lines up with bits [i*W +: W] of the flat bus.
  typedef struct packed {
    logic [DEF_LANES-1:0]                 mask;
    logic [DEF_LANES-1:0][DEF_DATA_W-1:0] instr;
    logic [DEF_LANES-1:0][DEF_PC_W-1:0]   pc;
  } lane_bundle_t;

  // Width of the flush discard counter; never narrower than one bit so a
  // zero-length window still yields a legal vector.
  function automatic int flush_cnt_w(input int flush_cyc);
    int w;
    w = $clog2(flush_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fetch_decode_skid_reg_if.sv
// Fetch-to-decode bundle bus.
//
// Handshake: a beat moves on a rising clk edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge; the
// consumer may raise or drop ready freely; ready never depends on valid in
// the same cycle. Upstream side: in_valid/in_ready. Downstream side:
// out_valid/out_ready.
interface fetch_decode_skid_reg_if
  import fetch_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W
) ();

  logic                      in_valid;
  logic [LANES-1:0]          in_lane_en;
  logic [LANES*DATA_W-1:0]   in_instr;
  logic [LANES*PC_W-1:0]     in_pc;
  logic                      in_ready;
  logic                      flush;
  logic                      out_valid;
  logic [LANES-1:0]          out_lane_en;
  logic [LANES*DATA_W-1:0]   out_instr;
  logic [LANES*PC_W-1:0]     out_pc;
  logic                      out_ready;
  logic                      flush_busy;
  logic [SQUASH_W-1:0]       squash_cnt;

  // Pipeline register view.
  modport slave (
    input  in_valid, in_lane_en, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_lane_en, out_instr, out_pc,
           flush_busy, squash_cnt
  );

  // Fetch/decode (environment) view.
  modport master (
    output in_valid, in_lane_en, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_lane_en, out_instr, out_pc,
           flush_busy, squash_cnt
  );

endinterface

// File: rtl/flush_bubble_ctr.sv
// Loadable down-counter that defines the post-flush discard window.
// Reloads on every flush, then counts down once per cycle to zero.
module flush_bubble_ctr #(
  parameter int W        = 2,
  parameter int LOAD_VAL = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  logic [W-1:0] count;

  // Reset clears, flush reloads, otherwise decrement until empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOAD_VAL);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/fetch_decode_skid_reg.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer, flush
// squash with a programmable discard window, and a squashed-lane counter.
module fetch_decode_skid_reg
  import fetch_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                PC_W      = DEF_PC_W,
  parameter int                LANES     = DEF_LANES,
  parameter int                FLUSH_CYC = 3,
  parameter logic [DATA_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input logic                   clk,
  input logic                   reset,
  fetch_decode_skid_reg_if.slave bus
);

  localparam int CNT_W = flush_cnt_w(FLUSH_CYC);

  typedef struct packed {
    logic                         valid;
    logic [LANES-1:0]             mask;
    logic [LANES-1:0][DATA_W-1:0] instr;
    logic [LANES-1:0][PC_W-1:0]   pc;
  } entry_t;

  entry_t                       main_q;
  entry_t                       skid_q;
  entry_t                       beat;
  logic                         in_ready;
  logic                         accept;
  logic                         consume;
  logic                         store_beat;
  logic                         discard_beat;
  logic                         flush_busy;
  logic [4:0]                   squash_add;
  logic [SQUASH_W:0]            squash_sum;
  logic [SQUASH_W-1:0]          squash_q;
  logic [LANES-1:0][DATA_W-1:0] out_instr_c;

  function automatic logic [2:0] pop(input logic [LANES-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + {2'b00, m[i]};
    return c;
  endfunction

  // Main-entry load: PCs of lanes the source does not enable keep their
  // previous value so decode always sees the last real PC per lane.
  function automatic entry_t load_main(input entry_t cur, input entry_t src);
    entry_t nxt;
    nxt       = cur;
    nxt.valid = 1'b1;
    nxt.mask  = src.mask;
    for (int i = 0; i < LANES; i++) begin
      nxt.instr[i] = src.instr[i];
      if (src.mask[i]) nxt.pc[i] = src.pc[i];
    end
    return nxt;
  endfunction

  flush_bubble_ctr #(
    .W        (CNT_W),
    .LOAD_VAL (FLUSH_CYC)
  ) u_flush_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (bus.flush),
    .busy  (flush_busy)
  );

  // Handshake qualifiers and the lane count squashed on this edge.
  // The beat presented in a flush cycle is squashed together with the
  // entries, whether or not the skid let it complete its handshake.
  always_comb begin
    beat.valid   = 1'b1;
    beat.mask    = bus.in_lane_en;
    beat.instr   = bus.in_instr;
    beat.pc      = bus.in_pc;
    in_ready     = !skid_q.valid;
    accept       = bus.in_valid && in_ready;
    consume      = main_q.valid && bus.out_ready;
    store_beat   = accept && !flush_busy && (bus.in_lane_en != '0);
    discard_beat = accept && flush_busy;
    squash_add   = '0;
    if (bus.flush) begin
      squash_add = 5'(pop(main_q.valid ? main_q.mask : '0))
                 + 5'(pop(skid_q.valid ? skid_q.mask : '0))
                 + 5'(pop(bus.in_valid ? bus.in_lane_en : '0));
    end else if (discard_beat) begin
      squash_add = 5'(pop(bus.in_lane_en));
    end
    squash_sum = {1'b0, squash_q} + (SQUASH_W+1)'(squash_add);
  end

  // Main and skid entries: reset > flush > consume/accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q.valid <= 1'b0;
      main_q.mask  <= '0;
      main_q.instr <= {LANES{NOP_INSTR}};
      main_q.pc    <= '0;
      skid_q       <= '0;
    end else if (bus.flush) begin
      main_q.valid <= 1'b0;
      main_q.mask  <= '0;
      skid_q.valid <= 1'b0;
    end else if (consume) begin
      if (skid_q.valid) begin
        main_q       <= load_main(main_q, skid_q);
        skid_q.valid <= 1'b0;
      end else if (store_beat) begin
        main_q <= load_main(main_q, beat);
      end else begin
        main_q.valid <= 1'b0;
        main_q.mask  <= '0;
      end
    end else if (!main_q.valid) begin
      if (store_beat) main_q <= load_main(main_q, beat);
    end else if (store_beat) begin
      skid_q <= beat;
    end
  end

  // Saturating count of lanes thrown away by flushes and the discard window.
  always_ff @(posedge clk) begin
    if (reset) begin
      squash_q <= '0;
    end else if (squash_add != '0) begin
      squash_q <= squash_sum[SQUASH_W] ? '1 : squash_sum[SQUASH_W-1:0];
    end
  end

  // Invalid lanes present NOP_INSTR to decode.
  always_comb begin
    out_instr_c = '0;
    for (int i = 0; i < LANES; i++) begin
      out_instr_c[i] = main_q.mask[i] ? main_q.instr[i] : NOP_INSTR;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = main_q.valid;
  assign bus.out_lane_en = main_q.mask;
  assign bus.out_instr   = out_instr_c;
  assign bus.out_pc      = main_q.pc;
  assign bus.flush_busy  = flush_busy;
  assign bus.squash_cnt  = squash_q;

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
// Directed bench for fetch_decode_skid_reg: a per-cycle vector table for
// streaming, stall/skid, partial lanes, flush and re-flush, followed by
// hand-written reset sequences.
module tb_fetch_decode_skid_reg;
  import fetch_pkg::*;

  localparam int LANES     = 2;
  localparam int DATA_W    = 32;
  localparam int PC_W      = 32;
  localparam int FLUSH_CYC = 3;

  logic clk;
  logic reset;

  fetch_decode_skid_reg_if #(.LANES(LANES), .DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  fetch_decode_skid_reg #(
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .LANES     (LANES),
    .FLUSH_CYC (FLUSH_CYC),
    .NOP_INSTR (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int total;
  int bad;
  logic [127:0] exp_q[$];

  typedef struct {
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    lane_bundle_t in_b;
    logic         exp_valid;
    logic         exp_ready;
    logic         exp_busy;
    logic [15:0]  exp_squash;
    lane_bundle_t exp_b;
  } vec_t;

  vec_t vecs[$];

  // Input beat n: instr lane0 = n*0x100, lane1 = n*0x100+1,
  // pc lane0 = 0x100 + 8*(n-1), lane1 = pc lane0 + 4.
  function automatic lane_bundle_t bb(input int n, input logic [1:0] m);
    lane_bundle_t b;
    b.mask     = m;
    b.instr[0] = 32'(n * 256);
    b.instr[1] = 32'(n * 256 + 1);
    b.pc[0]    = 32'(32'h100 + 8 * (n - 1));
    b.pc[1]    = 32'(32'h104 + 8 * (n - 1));
    return b;
  endfunction

  function automatic lane_bundle_t mk_out(input logic [1:0] m,
                                          input logic [31:0] i1, i0, p1, p0);
    lane_bundle_t b;
    b.mask     = m;
    b.instr[1] = i1;
    b.instr[0] = i0;
    b.pc[1]    = p1;
    b.pc[0]    = p0;
    return b;
  endfunction

  task automatic add(input logic fl, iv, ordy, input lane_bundle_t ib,
                     input logic ev, er, eb, input logic [15:0] sq,
                     input lane_bundle_t ob);
    vec_t v;
    v.flush      = fl;
    v.in_valid   = iv;
    v.out_ready  = ordy;
    v.in_b       = ib;
    v.exp_valid  = ev;
    v.exp_ready  = er;
    v.exp_busy   = eb;
    v.exp_squash = sq;
    v.exp_b      = ob;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, fl, iv, ordy, input lane_bundle_t b);
    @(negedge clk);
    reset          = rst;
    bus.flush      = fl;
    bus.in_valid   = iv;
    bus.out_ready  = ordy;
    bus.in_lane_en = b.mask;
    bus.in_instr   = b.instr;
    bus.in_pc      = b.pc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- checks ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, er, eb,
                               input logic [15:0] sq, input lane_bundle_t o);
    chk({tag, ".out_valid"},   128'(bus.out_valid),   128'(ev));
    chk({tag, ".in_ready"},    128'(bus.in_ready),    128'(er));
    chk({tag, ".flush_busy"},  128'(bus.flush_busy),  128'(eb));
    chk({tag, ".squash_cnt"},  128'(bus.squash_cnt),  128'(sq));
    chk({tag, ".out_lane_en"}, 128'(bus.out_lane_en), 128'(o.mask));
    chk({tag, ".out_instr"},   128'(bus.out_instr),   128'(o.instr));
    chk({tag, ".out_pc"},      128'(bus.out_pc),      128'(o.pc));
  endtask

  // ---------------- test ----------------
  initial begin
    lane_bundle_t zero_out;
    lane_bundle_t b20;
    logic [127:0] exp_word;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.in_lane_en = '0;
    bus.in_instr   = '0;
    bus.in_pc      = '0;
    zero_out = mk_out(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

    // Streaming: five beats, one per cycle, visible one edge later.
    for (int n = 1; n <= 5; n++)
      add(0, 1, 1, bb(n, 2'b11), 1, 1, 0, 16'd0, bb(n, 2'b11));
    add(0, 0, 1, bb(6, 2'b11), 0, 1, 0, 16'd0, mk_out(2'b00, 0, 0, 32'h124, 32'h120));
    // Stall: A (6) in main, B (7) into skid, C (8) held off, then drain in order.
    add(0, 1, 1, bb(6, 2'b11), 1, 1, 0, 16'd0, bb(6, 2'b11));
    add(0, 1, 0, bb(7, 2'b11), 1, 0, 0, 16'd0, bb(6, 2'b11));
    add(0, 1, 0, bb(8, 2'b11), 1, 0, 0, 16'd0, bb(6, 2'b11));
    add(0, 1, 0, bb(8, 2'b11), 1, 0, 0, 16'd0, bb(6, 2'b11));
    add(0, 1, 1, bb(8, 2'b11), 1, 1, 0, 16'd0, bb(7, 2'b11));
    add(0, 1, 1, bb(8, 2'b11), 1, 1, 0, 16'd0, bb(8, 2'b11));
    add(0, 0, 1, bb(9, 2'b11), 0, 1, 0, 16'd0, mk_out(2'b00, 0, 0, 32'h13C, 32'h138));
    // Partial lanes: lane 1 shows NOP and keeps its old PC; empty mask never stored.
    add(0, 1, 0, bb(9, 2'b01), 1, 1, 0, 16'd0, mk_out(2'b01, 32'h0, 32'h900, 32'h13C, 32'h140));
    add(0, 1, 1, bb(10, 2'b00), 0, 1, 0, 16'd0, mk_out(2'b00, 0, 0, 32'h13C, 32'h140));
    add(0, 1, 1, bb(10, 2'b00), 0, 1, 0, 16'd0, mk_out(2'b00, 0, 0, 32'h13C, 32'h140));
    // Flush with main and skid full and a beat presented: 2+2+2, then 3 discards.
    add(0, 1, 0, bb(11, 2'b11), 1, 1, 0, 16'd0, bb(11, 2'b11));
    add(0, 1, 0, bb(12, 2'b11), 1, 0, 0, 16'd0, bb(11, 2'b11));
    add(1, 1, 0, bb(13, 2'b11), 0, 1, 1, 16'd6,  mk_out(2'b00, 0, 0, 32'h154, 32'h150));
    add(0, 1, 1, bb(13, 2'b11), 0, 1, 1, 16'd8,  mk_out(2'b00, 0, 0, 32'h154, 32'h150));
    add(0, 1, 1, bb(14, 2'b11), 0, 1, 1, 16'd10, mk_out(2'b00, 0, 0, 32'h154, 32'h150));
    add(0, 1, 1, bb(15, 2'b11), 0, 1, 0, 16'd12, mk_out(2'b00, 0, 0, 32'h154, 32'h150));
    add(0, 1, 1, bb(16, 2'b11), 1, 1, 0, 16'd12, bb(16, 2'b11));
    add(0, 0, 1, bb(17, 2'b11), 0, 1, 0, 16'd12, mk_out(2'b00, 0, 0, 32'h17C, 32'h178));
    // Re-flush one cycle into the window: busy for 4 cycles total.
    add(1, 1, 1, bb(17, 2'b01), 0, 1, 1, 16'd13, mk_out(2'b00, 0, 0, 32'h17C, 32'h178));
    add(1, 1, 1, bb(18, 2'b11), 0, 1, 1, 16'd15, mk_out(2'b00, 0, 0, 32'h17C, 32'h178));
    add(0, 0, 1, bb(18, 2'b11), 0, 1, 1, 16'd15, mk_out(2'b00, 0, 0, 32'h17C, 32'h178));
    add(0, 0, 1, bb(18, 2'b11), 0, 1, 1, 16'd15, mk_out(2'b00, 0, 0, 32'h17C, 32'h178));
    add(0, 0, 1, bb(18, 2'b11), 0, 1, 0, 16'd15, mk_out(2'b00, 0, 0, 32'h17C, 32'h178));
    add(0, 1, 1, bb(17, 2'b11), 1, 1, 0, 16'd15, bb(17, 2'b11));

    // Reset state.
    drive(1, 0, 0, 0, zero_out);
    drive(1, 0, 0, 0, zero_out);
    check_outputs("reset", 0, 1, 0, 16'd0, zero_out);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].in_b);
      check_outputs($sformatf("row%0d", i + 1), vecs[i].exp_valid, vecs[i].exp_ready,
                    vecs[i].exp_busy, vecs[i].exp_squash, vecs[i].exp_b);
    end

    // Reset with the skid full.
    drive(0, 0, 1, 0, bb(18, 2'b11));
    chk("skid_full.in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("skid_full.out_valid", 128'(bus.out_valid), 128'(1'b1));
    drive(1, 0, 1, 1, bb(19, 2'b11));
    check_outputs("reset_skid", 0, 1, 0, 16'd0, zero_out);

    // Reset inside a discard window, then the first beat is stored.
    drive(0, 1, 1, 1, bb(19, 2'b11));
    chk("win.flush_busy", 128'(bus.flush_busy), 128'(1'b1));
    chk("win.squash_cnt", 128'(bus.squash_cnt), 128'(16'd2));
    drive(1, 0, 1, 1, bb(19, 2'b11));
    check_outputs("reset_window", 0, 1, 0, 16'd0, zero_out);
    b20 = bb(20, 2'b11);
    exp_q.push_back({b20.pc, b20.instr});
    drive(0, 0, 1, 0, b20);
    chk("post_reset.out_valid", 128'(bus.out_valid), 128'(1'b1));
    chk("post_reset.flush_busy", 128'(bus.flush_busy), 128'(1'b0));
    exp_word = exp_q.pop_front();
    chk("post_reset.bundle", {bus.out_pc, bus.out_instr}, exp_word);

    drive(0, 0, 0, 1, zero_out);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_skid_reg.md
# fetch_decode_skid_reg

Parametrised fetch-to-decode pipeline register for multi-issue fetch. It carries a bundle of instruction/PC lanes from the fetch stage to decode using a valid/ready handshake. A one-entry skid buffer lets upstream keep running for one cycle after a downstream stall. A flush squashes in-flight bundles and discards a programmable number of following fetch beats.

## Interface
- DATA_W, 32, instruction width per lane
- PC_W, 32, PC width per lane
- LANES, 2, instructions per fetch bundle (1..4)
- FLUSH_CYC, 3, cycles of input discard after a flush (0..7)
- NOP_INSTR, 32'h0, value driven on invalid lanes (DATA_W bits)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream bundle valid
- in_lane_en  in  LANES  per-lane valid mask of the incoming bundle
- in_instr  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- in_pc  in  LANES*PC_W  lane i at [i*PC_W +: PC_W]
- in_ready  out  1  register can accept a beat
- flush  in  1  branch/exception squash request
- out_valid  out  1  main entry holds a bundle
- out_lane_en  out  LANES  per-lane valid of the output bundle
- out_instr  out  LANES*DATA_W  NOP_INSTR on lanes whose out_lane_en bit is 0
- out_pc  out  LANES*PC_W  lane PC; holds its last value on invalid lanes
- out_ready  in  1  decode consumes the bundle (deassert = stall)
- flush_busy  out  1  discard window active
- squash_cnt  out  16  saturating count of lanes discarded since reset

## Operation
- Storage: main entry (feeds outputs) plus skid entry. Each entry holds a valid bit, a lane mask, instructions and PCs.
- in_ready = !skid_valid. It is registered, so there is no combinational path from out_ready.
- A beat is accepted when in_valid && in_ready.
- A beat with in_lane_en == 0 completes the handshake but is not stored.
- Consume: out_valid && out_ready.
- Main entry update rules:
  - On consume, main loads from skid if skid is valid, otherwise from the accepted beat, otherwise becomes invalid.
  - If main is empty, it loads the accepted beat.
- Skid load: an accepted beat goes to skid when main is valid and no consume occurs.
- Flush:
  - Main and skid valids clear on the same edge.
  - The flush counter loads FLUSH_CYC.
  - While the counter is nonzero, accepted beats are discarded and not stored; in_ready stays 1 during the window.
  - The counter decrements once per cycle, not once per beat.
- flush_busy = (counter != 0).
- Precedence, highest first: reset > flush > consume/accept.
  - A flush during an active window reloads FLUSH_CYC.
  - A beat accepted in the flush cycle itself is discarded.
- squash_cnt counts, on every flush or discard edge, the popcount of the discarded lane masks. This covers main, skid and incoming beats. The counter saturates at 16'hFFFF.
- FLUSH_CYC = 0: a flush clears the entries only; no window follows.

## Timing
- Latency: a beat accepted at edge N is visible on out_* after edge N (registered, 1 cycle).
- Throughput: 1 bundle/cycle while out_ready = 1.
- A stall costs upstream at most one extra accepted beat (into skid). in_ready drops the cycle after the skid fills and rises the cycle after the skid drains.
- The discard window spans exactly FLUSH_CYC cycles following the flush edge.
- Reset values:
  - out_valid 0, out_lane_en 0, out_instr all lanes NOP_INSTR, out_pc 0
  - in_ready 1, flush_busy 0, squash_cnt 0
  - Skid invalid, flush counter 0
- Reset mid-window clears the counter immediately; the next beat after reset is stored.

## Structure
- Shared package fetch_pkg holds:
  - Lane bundle typedef: mask, instr array, pc array
  - Default NOP_INSTR constant
  - Flush-counter width function $clog2(FLUSH_CYC+1)
- One sub-module: flush_bubble_ctr. It is the loadable down-counter producing flush_busy, with reload-on-flush and synchronous reset.
- Entry registers and the saturating squash counter stay in the top level.

## Test plan
- Streaming: LANES=2, out_ready=1. Five beats with PC 0x100/0x104 stepping by 8 appear on consecutive cycles, each 1 cycle later. in_ready stays 1.
- Stall and skid:
  - Drop out_ready for 3 cycles while beats stream.
  - Main holds beat A and skid holds beat B; in_ready = 0 from the second stall cycle.
  - On release, A then B emerge in order with no loss or duplication.
- Flush with FLUSH_CYC=3:
  - Assert flush with main and skid full (both masks 2'b11) and in_valid=1.
  - out_valid = 0 next cycle and flush_busy = 1 for 3 cycles.
  - The 3 streamed beats are dropped; squash_cnt = 2+2+2+6 = 12.
  - The 4th beat appears.
- Re-flush in window: a second flush 1 cycle into the window extends flush_busy to 4 total cycles.
- Partial lanes: in_lane_en=2'b01 drives out_instr lane 1 = NOP_INSTR, and out_pc lane 1 holds its previous value. A beat with in_lane_en=0 never raises out_valid.
- Reset mid-operation: assert reset during the discard window with skid full. All outputs take their reset values next cycle, and the first post-reset beat is stored.
